// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FIFO sizing, entry layout and status-register bit positions.
package uart_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;

    // One receive FIFO slot: the byte plus the framing/stop error seen with it.
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } uart_rx_fifo_entry_t;

    localparam int SR_RXNE_BIT  = 0;
    localparam int SR_RXOVR_BIT = 5;
    localparam int SR_RXTHR_BIT = 6;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: show-ahead head entry, level/threshold flags
// and a sticky overrun bit for bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int  DATA_W = 8,
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_err,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_err,
    output logic              empty,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    input  logic [LVL_W-1:0]  threshold,
    output logic              thr_reached,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             overrun_q;
    logic             push_ok;
    logic             pop_ok;
    logic             drop;

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        drop    = 1'b0;
        if (!flush) begin
            pop_ok  = pop && !empty;
            push_ok = push && (!full || pop);
            drop    = push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
            // A drop in the same cycle as ovr_clr must not be lost, so set beats clear.
            if (drop)         overrun_q <= 1'b1;
            else if (ovr_clr) overrun_q <= 1'b0;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; empty masks stale slots.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= entry_t'{err: push_err, data: push_data};
    end

    always_comb begin
        empty       = (level_q == '0);
        full        = (level_q == LVL_W'(DEPTH));
        level       = level_q;
        overrun     = overrun_q;
        thr_reached = (threshold != '0) && (level_q >= threshold);
        head        = empty ? '0 : mem[rd_ptr];
        head_data   = head.data;
        head_err    = head.err;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It captures every byte the receiver flags valid, together with its framing-error bit, into a circular FIFO. The UART register block pops bytes from it on RDR reads, so software no longer loses data when reads lag the line. It also reports level, threshold and sticky overrun status for the status register.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
DATA_W, 8, payload width per entry
LVL_W, $clog2(DEPTH+1), width of level and threshold (derived, not overridable)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
flush  in  1  discard all stored entries
push  in  1  receiver byte strobe (rx_data_valid), one-cycle pulse
push_data  in  DATA_W  received byte
push_err  in  1  framing/stop error for this byte
pop  in  1  consume head entry (RDR read), one-cycle pulse
head_data  out  DATA_W  head entry payload (show-ahead)
head_err  out  1  head entry error bit
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
level  out  LVL_W  number of stored entries, 0..DEPTH
threshold  in  LVL_W  watermark level
thr_reached  out  1  level >= threshold and threshold != 0
overrun  out  1  sticky: a push was dropped
ovr_clr  in  1  clear overrun

Behaviour:
- Clock and reset: single clock domain (clk). Reset is synchronous, active-high (rst).
- Reset values: empty=1, full=0, level=0, overrun=0, thr_reached=0, head_data=0, head_err=0. Internal pointers are 0. Memory contents are not reset.
- Storage: DEPTH x (DATA_W+1) array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - A separate level counter resolves full vs empty.
- Head data (show-ahead):
  - head_data/head_err = mem[rd_ptr], driven combinationally from the array.
  - Forced to 0 when empty.
  - A byte pushed in cycle N is visible on head_data in cycle N+1 (empty drops at N+1).
- Push:
  - When not full, or full with a simultaneous pop: write mem[wr_ptr], then wr_ptr+1.
  - When full without pop: data is dropped, overrun <= 1. Pointers and level are unchanged.
- Pop:
  - When not empty: rd_ptr+1.
  - When empty: ignored, no error, no state change.
- Level update:
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged on both or neither.
- Simultaneous push+pop:
  - Empty: push accepted, pop ignored, level becomes 1.
  - Full: both accepted, level stays DEPTH, no overrun.
- Flush:
  - Highest priority after rst. Next cycle: pointers=0, level=0, empty=1.
  - A same-cycle push or pop is discarded.
  - Overrun is NOT cleared by flush.
- Overrun:
  - Set on a dropped push; cleared only by ovr_clr.
  - Same-cycle set and ovr_clr: set wins, so overrun stays 1.
- Flags: empty, full and thr_reached are combinational from the registered level. threshold=0 disables thr_reached.
- Error bit: stored per entry and travels with its byte. It is never merged into overrun.
- Reset mid-operation: all state returns to reset values on the next edge, including overrun. In-flight push and pop are lost.

Decomposition:
- uart_pkg gains:
  - UART_RX_FIFO_DEPTH (=16).
  - uart_rx_fifo_entry_t packed struct {logic err; logic [7:0] data;}.
  - SR bit positions for rxovr and rxthr.
- Single flat module; no sub-module. Pointer/level logic is one always_ff; head read and flags are always_comb.
- Integration in uart: push <= rx_data_valid/rx_data/rx_error; pop <= RDR read handshake. SR.rxne is driven from !empty.

Test Plan:
- Reset, then push 0x41,0x42,0x43 on consecutive cycles -> level=3; head_data=0x41. Pop x3 -> reads 0x41,0x42,0x43; empty=1, head_data=0.
- Push 17 bytes 0x00..0x10 with DEPTH=16 -> full=1, overrun=1, level=16; 0x10 dropped. Pop 16 -> 0x00..0x0F in order. ovr_clr -> overrun=0.
- Fill to 16, then push 0xAA with a simultaneous pop -> level stays 16, overrun=0; last pop returns 0xAA. Empty FIFO with push 0x55 and pop in the same cycle -> level=1, head_data=0x55.
- threshold=4: push 3 -> thr_reached=0; 4th push -> thr_reached=1 next cycle. Pop 1 -> thr_reached=0. threshold=0 -> thr_reached=0 at any level.
- Push 0x12 with push_err=1, then 0x34 with push_err=0 -> head_err=1 with 0x12, then 0 with 0x34. overrun remains 0.
- Level 5, overrun=1. Assert flush with a simultaneous push 0x77 -> level=0, empty=1, overrun=1, 0x77 discarded. Then rst=1 for one cycle -> overrun=0, all outputs at reset values.
